testport_writer: RTL



---
 rtl/testport_writer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/testport_writer.sv
// -----------------------------------------------------------------------------
// testport_writer
//
// Writes a result sequence to the simulation test port. A sequence is a
// BEGIN_SYMBOL write, then the buffered result words in push order, then an
// END_SYMBOL write. Every write goes to TEST_PORT and is held for as long as
// stall_i is high. Each write is followed by at least one cycle with write
// enable low, so a monitor that filters stalls sees each write exactly once.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   start_i        one-cycle pulse that begins a sequence (honoured in IDLE only)
//   push_valid_i   a result word is offered
//   push_data_i    the offered result word
//   push_ready_o   the word is taken on an edge with push_valid_i & push_ready_o
//   done_req_i     pulse: no further words will be pushed
//   stall_i        bus stall; a write completes on an edge with wen_o & ~stall_i
//   addr_o         TEST_PORT while wen_o is high, otherwise 0
//   data_o         write data while wen_o is high, otherwise 0
//   wen_o          write enable
//   busy_o         high in every state except IDLE and DONE
//   sent_cnt_o     completed data-word writes (symbols excluded), saturating
//   finish_o       high in DONE
// -----------------------------------------------------------------------------
module testport_writer #(
    parameter logic [29:0] TEST_PORT    = 30'h3FF,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h0000_0168,
    parameter logic [31:0] END_SYMBOL   = 32'h0000_0D5D,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             push_valid_i,
    input  logic [31:0]      push_data_i,
    output logic             push_ready_o,
    input  logic             done_req_i,
    input  logic             stall_i,
    output logic [29:0]      addr_o,
    output logic [31:0]      data_o,
    output logic             wen_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] sent_cnt_o,
    output logic             finish_o
);

    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_BEGIN = 3'd1,
        S_GAP      = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WAIT     = 3'd4,
        S_WR_END   = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              end_pending_q, end_pending_d;
    logic [CNT_W-1:0]  sent_cnt_q;
    logic              wen_q, wen_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              full_s, empty_s, push_s, pop_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == '0);
    // Decoded from registered state only; no path from any input.
    assign push_ready_o = ~full_s & ~end_pending_q & (state_q != S_DONE);
    assign push_s       = push_valid_i & push_ready_o;
    // A data write completes (and the head is consumed) only when not stalled.
    assign pop_s        = (state_q == S_WR_DATA) & ~stall_i;

    // Next-state logic of the write sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_WR_BEGIN;
                else         state_d = S_IDLE;
            end
            S_WR_BEGIN: begin
                if (!stall_i) state_d = S_GAP;
                else          state_d = S_WR_BEGIN;
            end
            S_WR_DATA: begin
                if (!stall_i) state_d = S_GAP;
                else          state_d = S_WR_DATA;
            end
            // count_q excludes a push on this edge, so a new word is never
            // written in the cycle right after it was pushed.
            S_GAP, S_WAIT: begin
                if (!empty_s)           state_d = S_WR_DATA;
                else if (end_pending_q) state_d = S_WR_END;
                else                    state_d = S_WAIT;
            end
            S_WR_END: begin
                if (!stall_i) state_d = S_DONE;
                else          state_d = S_WR_END;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs for the coming cycle, derived from the next state. Under a
    // stall the state and FIFO head are unchanged, so the write is re-driven.
    always_comb begin
        wen_d  = 1'b0;
        data_d = 32'h0000_0000;
        addr_d = 30'h0;
        case (state_d)
            S_WR_BEGIN: begin wen_d = 1'b1; data_d = BEGIN_SYMBOL;    end
            S_WR_DATA:  begin wen_d = 1'b1; data_d = mem_q[rd_ptr_q]; end
            S_WR_END:   begin wen_d = 1'b1; data_d = END_SYMBOL;      end
            default:    begin wen_d = 1'b0; data_d = 32'h0000_0000;   end
        endcase
        if (wen_d) addr_d = TEST_PORT;
        else       addr_d = 30'h0;
    end

    // end_pending: set by done_req outside DONE, cleared on entry to DONE.
    always_comb begin
        end_pending_d = end_pending_q;
        if (state_q == S_DONE)      end_pending_d = 1'b0;
        else if (state_d == S_DONE) end_pending_d = 1'b0;
        else if (done_req_i)        end_pending_d = 1'b1;
        else                        end_pending_d = end_pending_q;
    end

    // Sequencer state, bus output registers and end_pending flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            wen_q         <= 1'b0;
            addr_q        <= 30'h0;
            data_q        <= 32'h0000_0000;
            end_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wen_q         <= wen_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            end_pending_q <= end_pending_d;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Completed data-word writes, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                        sent_cnt_q <= '0;
        else if (pop_s && (sent_cnt_q != {CNT_W{1'b1}})) sent_cnt_q <= sent_cnt_q + CNT_W'(1);
        else                                              sent_cnt_q <= sent_cnt_q;
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign wen_o      = wen_q;
    assign sent_cnt_o = sent_cnt_q;
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finish_o   = (state_q == S_DONE);

endmodule
